// File: rtl/data_in_sequencer_pkg.sv
// Shared definitions for the byte-lane sequencer and its decoder-side consumers:
// word geometry, lane width and the FILL/HOLD state encoding.
package data_in_sequencer_pkg;

   localparam int WORD_BYTES = 4;
   localparam int LANE_W     = 2;
   localparam int WORD_W     = 8 * WORD_BYTES;

   typedef enum logic {
      ST_FILL = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   function automatic logic lane_is_last(input logic [LANE_W-1:0] lane);
      return lane == LANE_W'(WORD_BYTES - 1);
   endfunction

endpackage

// File: rtl/data_in_idle_timer.sv
// Idle timer: counts enabled cycles and pulses expire on the cycle whose edge
// would bring the count to TIMEOUT_CYCLES. TIMEOUT_CYCLES=0 disables expiry.
module data_in_idle_timer #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int TMR_W          = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   output logic expire
);

   localparam int               LIMIT_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
   localparam logic [TMR_W-1:0] LIMIT   = LIMIT_I[TMR_W-1:0];

   logic [TMR_W-1:0] count_q;
   logic             hit;

   assign hit = en && (count_q == LIMIT);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         count_q <= '0;
      end else if (en) begin
         count_q <= hit ? '0 : count_q + TMR_W'(1);
      end
   end

   generate
      if (TIMEOUT_CYCLES == 0) begin : g_disabled
         assign expire = 1'b0;
      end else begin : g_enabled
         assign expire = hit;
      end
   endgenerate

endmodule

// File: rtl/data_in_sequencer.sv
// Byte-stream to 32-bit word sequencer: assigns little-endian lanes, mirrors each
// accepted byte to the decoder, and flushes partial words on last or idle timeout.
module data_in_sequencer
   import data_in_sequencer_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int TMR_W          = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              byte_valid,
   output logic              byte_ready,
   input  logic [7:0]        byte_data,
   input  logic              byte_last,
   output logic [7:0]        dec_data,
   output logic [LANE_W-1:0] dec_sel,
   output logic              word_valid,
   input  logic              word_ready,
   output logic [WORD_W-1:0] word_data,
   output logic [WORD_BYTES-1:0] word_keep,
   output logic              word_tout
);

   state_t                  state_q, state_d;
   logic                    run_q;
   logic [LANE_W-1:0]       lane_q, lane_d;
   logic [WORD_BYTES-1:0]   keep_q, keep_d;
   logic [WORD_W-1:0]       word_q, word_d;
   logic                    tout_q, tout_d;
   logic [7:0]              dec_data_q, dec_data_d;
   logic [LANE_W-1:0]       dec_sel_q, dec_sel_d;

   logic accept;
   logic tmr_en, tmr_clr, expire;

   // run_q keeps byte_ready low through the reset cycle itself.
   assign byte_ready = run_q && (state_q == ST_FILL);
   assign accept     = byte_valid && byte_ready;

   assign tmr_en  = (state_q == ST_FILL) && (keep_q != '0) && !accept;
   assign tmr_clr = accept || (state_q == ST_HOLD) || (keep_q == '0);

   data_in_idle_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .TMR_W          (TMR_W)
   ) u_idle_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (tmr_en),
      .clr    (tmr_clr),
      .expire (expire)
   );

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d    = state_q;
      lane_d     = lane_q;
      keep_d     = keep_q;
      word_d     = word_q;
      tout_d     = tout_q;
      dec_data_d = dec_data_q;
      dec_sel_d  = dec_sel_q;

      case (state_q)
         ST_FILL: begin
            if (accept) begin
               word_d[{lane_q, 3'b000} +: 8] = byte_data;
               keep_d[lane_q]                = 1'b1;
               dec_data_d                    = byte_data;
               dec_sel_d                     = lane_q;
               lane_d                        = lane_q + LANE_W'(1);
               if (lane_is_last(lane_q) || byte_last) begin
                  state_d = ST_HOLD;
                  tout_d  = 1'b0;
               end
            end else if (expire) begin
               state_d = ST_HOLD;
               tout_d  = 1'b1;
            end
         end
         ST_HOLD: begin
            if (word_ready) begin
               state_d = ST_FILL;
               lane_d  = '0;
               keep_d  = '0;
               word_d  = '0;
               tout_d  = 1'b0;
            end
         end
         default: state_d = ST_FILL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_FILL;
         run_q      <= 1'b0;
         lane_q     <= '0;
         keep_q     <= '0;
         word_q     <= '0;
         tout_q     <= 1'b0;
         dec_data_q <= '0;
         dec_sel_q  <= '0;
      end else begin
         state_q    <= state_d;
         run_q      <= 1'b1;
         lane_q     <= lane_d;
         keep_q     <= keep_d;
         word_q     <= word_d;
         tout_q     <= tout_d;
         dec_data_q <= dec_data_d;
         dec_sel_q  <= dec_sel_d;
      end
   end

   assign word_valid = (state_q == ST_HOLD);
   assign word_data  = word_q;
   assign word_keep  = keep_q;
   assign word_tout  = tout_q;
   assign dec_data   = dec_data_q;
   assign dec_sel    = dec_sel_q;

endmodule

// File: tb/tb_data_in_sequencer.sv
// Self-checking bench for data_in_sequencer: a queue-based word model checked
// every cycle, plus directed scenarios with hand-computed literal expectations.
module tb_data_in_sequencer;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        byte_valid = 1'b0;
   logic        byte_last = 1'b0;
   logic [7:0]  byte_data = '0;
   logic        word_ready = 1'b0;
   logic        byte_ready;
   logic [7:0]  dec_data;
   logic [1:0]  dec_sel;
   logic        word_valid;
   logic [31:0] word_data;
   logic [3:0]  word_keep;
   logic        word_tout;

   int checks = 0;
   int failures = 0;

   data_in_sequencer #(
      .TIMEOUT_CYCLES (TO),
      .TMR_W          (8)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .byte_valid (byte_valid),
      .byte_ready (byte_ready),
      .byte_data  (byte_data),
      .byte_last  (byte_last),
      .dec_data   (dec_data),
      .dec_sel    (dec_sel),
      .word_valid (word_valid),
      .word_ready (word_ready),
      .word_data  (word_data),
      .word_keep  (word_keep),
      .word_tout  (word_tout)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: the current word is just the list of bytes taken so far.
   bit          m_live = 1'b0;
   bit          m_run = 1'b0;
   bit          m_hold = 1'b0;
   bit          m_tout = 1'b0;
   int          m_idle = 0;
   logic [7:0]  m_q[$];
   logic [7:0]  m_dec = '0;
   logic [1:0]  m_sel = '0;

   function automatic logic [31:0] exp_word();
      logic [31:0] w = '0;
      foreach (m_q[i]) w = w | (32'(m_q[i]) << (8 * i));
      return w;
   endfunction

   function automatic logic [31:0] exp_keep();
      return (32'd1 << m_q.size()) - 32'd1;
   endfunction

   always @(posedge clk) begin : model
      bit acc;
      if (!rst_n) begin
         m_live = 1'b1;
         m_run  = 1'b0;
         m_hold = 1'b0;
         m_tout = 1'b0;
         m_idle = 0;
         m_q.delete();
         m_dec  = '0;
         m_sel  = '0;
      end else begin
         acc = byte_valid && m_run && !m_hold;
         if (m_hold) begin
            if (word_ready) begin
               m_hold = 1'b0;
               m_tout = 1'b0;
               m_idle = 0;
               m_q.delete();
            end
         end else if (acc) begin
            m_sel = 2'(m_q.size());
            m_dec = byte_data;
            m_q.push_back(byte_data);
            m_idle = 0;
            if (m_q.size() == 4 || byte_last) begin
               m_hold = 1'b1;
               m_tout = 1'b0;
            end
         end else if (m_q.size() != 0) begin
            m_idle++;
            if (m_idle == TO) begin
               m_hold = 1'b1;
               m_tout = 1'b1;
               m_idle = 0;
            end
         end
         m_run = 1'b1;
      end
   end

   always @(negedge clk) begin
      if (m_live) begin
         check("m_byte_ready", byte_ready, m_run && !m_hold);
         check("m_word_valid", word_valid, m_hold);
         check("m_dec_data", dec_data, m_dec);
         check("m_dec_sel", dec_sel, m_sel);
         if (m_hold) begin
            check("m_word_data", word_data, exp_word());
            check("m_word_keep", word_keep, exp_keep());
            check("m_word_tout", word_tout, m_tout);
         end
      end
   end

   // Called just after a negedge; returns just after the negedge following acceptance.
   task automatic send(input logic [7:0] b, input logic last);
      int n = 0;
      byte_valid = 1'b1;
      byte_data  = b;
      byte_last  = last;
      while (!byte_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!byte_ready) check("send_ready_timeout", byte_ready, 1);
      @(negedge clk);
      byte_valid = 1'b0;
      byte_last  = 1'b0;
   endtask

   task automatic wait_valid(input int max);
      int n = 0;
      while (!word_valid && n < max) begin
         @(negedge clk);
         n++;
      end
      check("wait_valid", word_valid, 1);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      logic [7:0] t1 [4];
      t1[0] = 8'h11; t1[1] = 8'h22; t1[2] = 8'h33; t1[3] = 8'h44;

      rst_n = 1'b0;
      word_ready = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      check("rst_byte_ready", byte_ready, 0);
      check("rst_word_valid", word_valid, 0);
      check("rst_dec_sel", dec_sel, 0);
      @(negedge clk);
      check("ready_after_rst", byte_ready, 1);

      // 1. full word, word_ready high
      for (int i = 0; i < 4; i++) begin
         send(t1[i], 1'b0);
         check("t1_dec_sel", dec_sel, i);
         check("t1_dec_data", dec_data, t1[i]);
         if (i < 3) check("t1_not_valid", word_valid, 0);
      end
      check("t1_valid", word_valid, 1);
      check("t1_data", word_data, 32'h44332211);
      check("t1_keep", word_keep, 4'hF);
      check("t1_tout", word_tout, 0);
      check("t1_ready_low", byte_ready, 0);

      // 2. early last
      send(8'hAA, 1'b0);
      send(8'hBB, 1'b1);
      check("t2_valid", word_valid, 1);
      check("t2_data", word_data, 32'h0000BBAA);
      check("t2_keep", word_keep, 4'b0011);
      check("t2_tout", word_tout, 0);
      @(negedge clk);

      // 3. timeout flush, then a byte on the expire cycle
      word_ready = 1'b0;
      send(8'h5C, 1'b0);
      check("t3_idle0", word_valid, 0);
      for (int k = 1; k < TO; k++) begin
         @(negedge clk);
         check("t3_idle", word_valid, 0);
      end
      @(negedge clk);
      check("t3_valid", word_valid, 1);
      check("t3_data", word_data, 32'h0000005C);
      check("t3_keep", word_keep, 4'h1);
      check("t3_tout", word_tout, 1);
      word_ready = 1'b1;
      @(negedge clk);
      word_ready = 1'b0;
      send(8'hA0, 1'b0);
      repeat (TO - 1) @(negedge clk);
      send(8'hB1, 1'b0);
      check("t3b_no_flush", word_valid, 0);
      check("t3b_keep", word_keep, 4'h3);
      for (int k = 1; k < TO; k++) begin
         @(negedge clk);
         check("t3b_idle", word_valid, 0);
      end
      @(negedge clk);
      check("t3b_valid", word_valid, 1);
      check("t3b_data", word_data, 32'h0000B1A0);
      check("t3b_keep2", word_keep, 4'h3);
      check("t3b_tout", word_tout, 1);
      word_ready = 1'b1;
      @(negedge clk);

      // 4. backpressure with a byte waiting
      word_ready = 1'b0;
      send(8'h01, 1'b0);
      send(8'h02, 1'b0);
      send(8'h03, 1'b0);
      send(8'h04, 1'b0);
      byte_valid = 1'b1;
      byte_data  = 8'h77;
      for (int k = 0; k < 10; k++) begin
         check("t4_ready_low", byte_ready, 0);
         check("t4_valid", word_valid, 1);
         check("t4_data", word_data, 32'h04030201);
         check("t4_keep", word_keep, 4'hF);
         @(negedge clk);
      end
      word_ready = 1'b1;
      @(negedge clk);
      check("t4_after_hs_valid", word_valid, 0);
      check("t4_after_hs_ready", byte_ready, 1);
      check("t4_no_accept_in_hs", dec_data, 8'h04);
      @(negedge clk);
      byte_valid = 1'b0;
      check("t4_next_dec_data", dec_data, 8'h77);
      check("t4_next_dec_sel", dec_sel, 0);
      wait_valid(20);
      check("t4_tail_keep", word_keep, 4'h1);
      check("t4_tail_tout", word_tout, 1);
      @(negedge clk);

      // 5. reset mid-word
      send(8'hC1, 1'b0);
      send(8'hC2, 1'b0);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("t5_ready", byte_ready, 0);
      check("t5_valid", word_valid, 0);
      check("t5_dec_data", dec_data, 0);
      check("t5_dec_sel", dec_sel, 0);
      check("t5_keep", word_keep, 0);
      check("t5_data", word_data, 0);
      check("t5_tout", word_tout, 0);
      word_ready = 1'b0;
      send(8'hD1, 1'b0);
      send(8'hD2, 1'b0);
      send(8'hD3, 1'b0);
      send(8'hD4, 1'b0);
      check("t5_word_valid", word_valid, 1);
      check("t5_word_data", word_data, 32'hD4D3D2D1);
      check("t5_word_keep", word_keep, 4'hF);
      word_ready = 1'b1;
      repeat (2) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
